// File: rtl/usart_pkg.sv
// Shared types and constants for the USART baud clock sequencer.
// The lock monitor is compiled in when USART_BAUD_CTRL_LOCK_EN is defined.
package usart_pkg;

  typedef logic [3:0] baud_idx_t;

  localparam baud_idx_t MAX_BAUD_IDX = 4'd13;

  localparam baud_idx_t DEF_BAUD = 4'd2;
  localparam logic      DEF_MODE = 1'b0;
  localparam logic      DEF_SYNC = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    HOLD,
    APPLY,
    LOCK,
    ACK
  } state_t;

  typedef struct packed {
    baud_idx_t baud;
    logic      mode;
    logic      sync;
  } cfg_t;

  function automatic logic baud_ok(input baud_idx_t idx);
    return idx <= MAX_BAUD_IDX;
  endfunction

endpackage

// File: rtl/usart_baud_ctrl_if.sv
// Reconfiguration request/acknowledge bundle between the two requesters and the sequencer.
// The master side drives requests; the slave side (the sequencer) returns Ack/AckErr.
interface usart_baud_ctrl_if;
  import usart_pkg::*;

  logic      ReqA_Valid;
  baud_idx_t ReqA_Baud;
  logic      ReqA_Mode;
  logic      ReqA_Sync;
  logic      ReqA_Ack;

  logic      ReqB_Valid;
  baud_idx_t ReqB_Baud;
  logic      ReqB_Mode;
  logic      ReqB_Sync;
  logic      ReqB_Ack;

  logic      AckErr;

  modport master (
    output ReqA_Valid, ReqA_Baud, ReqA_Mode, ReqA_Sync,
    output ReqB_Valid, ReqB_Baud, ReqB_Mode, ReqB_Sync,
    input  ReqA_Ack, ReqB_Ack, AckErr
  );

  modport slave (
    input  ReqA_Valid, ReqA_Baud, ReqA_Mode, ReqA_Sync,
    input  ReqB_Valid, ReqB_Baud, ReqB_Mode, ReqB_Sync,
    output ReqA_Ack, ReqB_Ack, AckErr
  );

endinterface

// File: rtl/usart_clk_lock_det.sv
// INClk lock monitor: 2-flop synchronizer, registered rising-edge detector and timeout counter.
// Only instantiated when USART_BAUD_CTRL_LOCK_EN is defined.
module usart_clk_lock_det #(
  parameter int LOCK_TIMEOUT = 32768
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic inclk,
  output logic rise,
  output logic timeout
);

  logic [1:0]  sync_q;
  logic        prev_q;
  logic [15:0] cnt;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b1;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], inclk};
      if (clr) begin
        // prev forced high so an edge that slipped in before the clear is not counted
        prev_q <= 1'b1;
        rise   <= 1'b0;
        cnt    <= '0;
      end else begin
        prev_q <= sync_q[1];
        rise   <= sync_q[1] & ~prev_q;
        if (en && !timeout) cnt <= cnt + 16'd1;
      end
    end
  end

  assign timeout = (cnt == 16'(LOCK_TIMEOUT));

endmodule

// File: rtl/usart_baud_ctrl.sv
// Round-robin sequencer that drains, resets, reprograms and (optionally) lock-checks the baud generator.
// Define USART_BAUD_CTRL_LOCK_EN to compile in the INClk lock check and timeout.
module usart_baud_ctrl
  import usart_pkg::*;
#(
  parameter int HOLD_CYCLES  = 4,
  parameter int LOCK_TIMEOUT = 32768
) (
  input  logic                 CPUClk,
  input  logic                 Reset,
  usart_baud_ctrl_if.slave     req,
  input  logic                 TxBusy,
  input  logic                 RxBusy,
  input  logic                 INClk,
  output logic                 GenReset,
  output baud_idx_t            Baudrate,
  output logic                 Mode,
  output logic                 Sync,
  output logic                 CfgValid
);

  state_t     state;
  logic [3:0] hold_cnt;
  cfg_t       pend;
  logic       grant_b;
  logic       last_b;
  logic       boot;
  logic       pick_b;
  cfg_t       sel_cfg;

  always_comb begin
    // NOTE: every always_comb output is assigned on all paths so no latch is inferred.
    pick_b  = req.ReqB_Valid && (!req.ReqA_Valid || !last_b);
    sel_cfg = pick_b ? cfg_t'{req.ReqB_Baud, req.ReqB_Mode, req.ReqB_Sync}
                     : cfg_t'{req.ReqA_Baud, req.ReqA_Mode, req.ReqA_Sync};
  end

`ifdef USART_BAUD_CTRL_LOCK_EN
  logic lock_rise;
  logic lock_timeout;

  usart_clk_lock_det #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_lock_det (
    .clk     (CPUClk),
    .rst_n   (Reset),
    .clr     (state == APPLY),
    .en      (state == LOCK),
    .inclk   (INClk),
    .rise    (lock_rise),
    .timeout (lock_timeout)
  );
`else
  logic unused_inclk;
  assign unused_inclk = INClk;
`endif

  always_ff @(posedge CPUClk or negedge Reset) begin
    if (!Reset) begin
      // reset lands in HOLD so release replays the power-on programming sequence
      state        <= HOLD;
      hold_cnt     <= '0;
      pend         <= cfg_t'{DEF_BAUD, DEF_MODE, DEF_SYNC};
      grant_b      <= 1'b0;
      last_b       <= 1'b1;
      boot         <= 1'b1;
      GenReset     <= 1'b1;
      Baudrate     <= DEF_BAUD;
      Mode         <= DEF_MODE;
      Sync         <= DEF_SYNC;
      CfgValid     <= 1'b0;
      req.ReqA_Ack <= 1'b0;
      req.ReqB_Ack <= 1'b0;
      req.AckErr   <= 1'b0;
    end else begin
      req.ReqA_Ack <= 1'b0;
      req.ReqB_Ack <= 1'b0;
      req.AckErr   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req.ReqA_Valid || req.ReqB_Valid) begin
            grant_b <= pick_b;
            last_b  <= pick_b;
            pend    <= sel_cfg;
            if (baud_ok(sel_cfg.baud)) begin
              state <= DRAIN;
            end else begin
              state        <= ACK;
              req.AckErr   <= 1'b1;
              req.ReqA_Ack <= !pick_b;
              req.ReqB_Ack <= pick_b;
            end
          end
        end
        DRAIN: begin
          if (!TxBusy && !RxBusy) begin
            state    <= HOLD;
            hold_cnt <= '0;
            GenReset <= 1'b1;
            CfgValid <= 1'b0;
            Baudrate <= pend.baud;
            Mode     <= pend.mode;
            Sync     <= pend.sync;
          end
        end
        HOLD: begin
          if (hold_cnt == 4'(HOLD_CYCLES - 1)) begin
            state    <= APPLY;
            GenReset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        APPLY: begin
`ifdef USART_BAUD_CTRL_LOCK_EN
          state <= LOCK;
`else
          state        <= ACK;
          CfgValid     <= 1'b1;
          boot         <= 1'b0;
          req.ReqA_Ack <= !boot && !grant_b;
          req.ReqB_Ack <= !boot && grant_b;
`endif
        end
        LOCK: begin
`ifdef USART_BAUD_CTRL_LOCK_EN
          if (lock_rise || lock_timeout) begin
            state        <= ACK;
            CfgValid     <= lock_rise;
            boot         <= 1'b0;
            req.AckErr   <= !boot && !lock_rise;
            req.ReqA_Ack <= !boot && !grant_b;
            req.ReqB_Ack <= !boot && grant_b;
          end
`else
          state <= IDLE;
`endif
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_baud_ctrl.sv
// Directed self-checking bench for usart_baud_ctrl; expectations follow USART_BAUD_CTRL_LOCK_EN.
module tb_usart_baud_ctrl;
  import usart_pkg::*;

  localparam int HOLD = 4;
  localparam int TMO  = 32768;

  logic      CPUClk = 1'b0;
  logic      Reset  = 1'b0;
  logic      TxBusy = 1'b0;
  logic      RxBusy = 1'b0;
  logic      INClk  = 1'b0;
  logic      GenReset;
  baud_idx_t Baudrate;
  logic      Mode;
  logic      Sync;
  logic      CfgValid;

  bit inclk_run = 1'b0;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_ack_a = 0;
  int n_ack_b = 0;

  usart_baud_ctrl_if ifc ();

  usart_baud_ctrl #(.HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(TMO)) dut (
    .CPUClk   (CPUClk),
    .Reset    (Reset),
    .req      (ifc),
    .TxBusy   (TxBusy),
    .RxBusy   (RxBusy),
    .INClk    (INClk),
    .GenReset (GenReset),
    .Baudrate (Baudrate),
    .Mode     (Mode),
    .Sync     (Sync),
    .CfgValid (CfgValid)
  );

  always #5 CPUClk = ~CPUClk;

  always begin
    #7;
    INClk = inclk_run ? ~INClk : 1'b0;
  end

  always @(posedge CPUClk) begin
    cyc <= cyc + 1;
    if (ifc.ReqA_Ack === 1'b1) n_ack_a <= n_ack_a + 1;
    if (ifc.ReqB_Ack === 1'b1) n_ack_b <= n_ack_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input bit side, input logic [3:0] baud, input logic mode, input logic sync);
    if (!side) begin
      ifc.ReqA_Baud = baud; ifc.ReqA_Mode = mode; ifc.ReqA_Sync = sync; ifc.ReqA_Valid = 1'b1;
    end else begin
      ifc.ReqB_Baud = baud; ifc.ReqB_Mode = mode; ifc.ReqB_Sync = sync; ifc.ReqB_Valid = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit side, input int budget,
                          output logic err, output logic cfg, output int at);
    bit seen = 1'b0;
    err = 1'b0; cfg = 1'b0; at = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CPUClk);
      if ((side ? ifc.ReqB_Ack : ifc.ReqA_Ack) === 1'b1) begin
        seen = 1'b1; err = ifc.AckErr; cfg = CfgValid; at = cyc;
      end
    end
    if (!side) ifc.ReqA_Valid = 1'b0; else ifc.ReqB_Valid = 1'b0;
    check(side ? "ackB_seen" : "ackA_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_cfgvalid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CPUClk);
      seen = (CfgValid === 1'b1);
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic count_genreset(output int n);
    n = 0;
    while (GenReset === 1'b1 && n < 50) begin
      n++;
      @(negedge CPUClk);
    end
  endtask

  initial begin
    logic ea, ca, eb, cb;
    int   ta, tb, n, st, viol;

    ifc.ReqA_Valid = 1'b0; ifc.ReqA_Baud = '0; ifc.ReqA_Mode = 1'b0; ifc.ReqA_Sync = 1'b0;
    ifc.ReqB_Valid = 1'b0; ifc.ReqB_Baud = '0; ifc.ReqB_Mode = 1'b0; ifc.ReqB_Sync = 1'b0;

    // values held during reset
    repeat (3) @(negedge CPUClk);
    check("rst_genreset", 32'(GenReset), 32'd1);
    check("rst_baud", 32'(Baudrate), 32'd2);
    check("rst_mode_sync", 32'({Mode, Sync}), 32'd0);
    check("rst_cfgvalid", 32'(CfgValid), 32'd0);
    check("rst_acks", 32'({ifc.ReqA_Ack, ifc.ReqB_Ack, ifc.AckErr}), 32'd0);

    // power-on sequence
    inclk_run = 1'b1;
    Reset = 1'b1;
    count_genreset(n);
    check("por_hold_cycles", 32'(n), 32'(HOLD));
    check("por_baud", 32'(Baudrate), 32'd2);
    wait_cfgvalid("por_cfgvalid", 50);
    repeat (3) @(negedge CPUClk);
    check("por_no_ack", 32'(n_ack_a + n_ack_b), 32'd0);

    // single request from A
    start_req(1'b0, 4'd9, 1'b0, 1'b0);
    @(negedge CPUClk);
    check("single_drain_genreset", 32'(GenReset), 32'd0);
    check("single_drain_baud", 32'(Baudrate), 32'd2);
    @(negedge CPUClk);
    check("single_hold_genreset", 32'(GenReset), 32'd1);
    check("single_hold_baud", 32'(Baudrate), 32'd9);
    check("single_hold_cfgvalid", 32'(CfgValid), 32'd0);
    repeat (HOLD - 1) @(negedge CPUClk);
    check("single_hold_last", 32'(GenReset), 32'd1);
    @(negedge CPUClk);
    check("single_apply", 32'(GenReset), 32'd0);
    wait_ack(1'b0, 100, ea, ca, ta);
    check("single_ackerr", 32'(ea), 32'd0);
    check("single_cfgvalid", 32'(ca), 32'd1);
    repeat (3) @(negedge CPUClk);
    check("single_ack_once", 32'(n_ack_a), 32'd1);
    check("single_no_ack_b", 32'(n_ack_b), 32'd0);

    // drain: receiver busy blocks reconfiguration
    RxBusy = 1'b1;
    start_req(1'b1, 4'd4, 1'b0, 1'b0);
    viol = 0;
    repeat (200) begin
      @(negedge CPUClk);
      if (GenReset !== 1'b0 || Baudrate !== 4'd9 || CfgValid !== 1'b1) viol++;
    end
    check("drain_held_off", 32'(viol), 32'd0);
    RxBusy = 1'b0;
    @(negedge CPUClk);
    check("drain_exit_genreset", 32'(GenReset), 32'd1);
    check("drain_exit_baud", 32'(Baudrate), 32'd4);
    wait_ack(1'b1, 100, eb, cb, tb);
    check("drain_ackerr", 32'(eb), 32'd0);
    check("drain_cfgvalid", 32'(cb), 32'd1);
    repeat (3) @(negedge CPUClk);
    check("drain_ack_once", 32'(n_ack_b), 32'd1);

    // contention round 1: B was granted last, so A wins
    start_req(1'b0, 4'd5, 1'b0, 1'b0);
    start_req(1'b1, 4'd7, 1'b1, 1'b0);
    fork
      wait_ack(1'b0, 200, ea, ca, ta);
      wait_ack(1'b1, 200, eb, cb, tb);
    join
    check("rr1_a_first", 32'(ta < tb), 32'd1);
    check("rr1_errs", 32'({ea, eb}), 32'd0);
`ifndef USART_BAUD_CTRL_LOCK_EN
    check("rr1_b2b_gap", 32'(tb - ta), 32'd8);
`endif
    check("rr1_final_cfg", 32'({Baudrate, Mode, Sync}), 32'({4'd7, 1'b1, 1'b0}));
    repeat (2) @(negedge CPUClk);

    // invalid baud indices: acked at N+1 with AckErr, outputs untouched
    for (int k = 0; k < 2; k++) begin
      logic [3:0] bad;
      bad = (k == 0) ? 4'd15 : 4'd14;
      start_req(1'b0, bad, 1'b0, 1'b0);
      @(negedge CPUClk);
      check("inv_ack", 32'(ifc.ReqA_Ack), 32'd1);
      check("inv_ackerr", 32'(ifc.AckErr), 32'd1);
      check("inv_outputs", 32'({Baudrate, Mode, Sync, CfgValid, GenReset}),
            32'({4'd7, 1'b1, 1'b0, 1'b1, 1'b0}));
      ifc.ReqA_Valid = 1'b0;
      @(negedge CPUClk);
      check("inv_ack_once", 32'(ifc.ReqA_Ack), 32'd0);
      @(negedge CPUClk);
    end

    // contention round 2: A was granted last, so B wins
    start_req(1'b0, 4'd3, 1'b0, 1'b1);
    start_req(1'b1, 4'd11, 1'b0, 1'b0);
    fork
      wait_ack(1'b0, 200, ea, ca, ta);
      wait_ack(1'b1, 200, eb, cb, tb);
    join
    check("rr2_b_first", 32'(tb < ta), 32'd1);
    check("rr2_errs", 32'({ea, eb}), 32'd0);
    check("rr2_final_cfg", 32'({Baudrate, Mode, Sync}), 32'({4'd3, 1'b0, 1'b1}));
    repeat (3) @(negedge CPUClk);
    check("rr_ack_counts", 32'({n_ack_a[15:0], n_ack_b[15:0]}), 32'({16'd5, 16'd3}));

    // INClk stuck low
    inclk_run = 1'b0;
    repeat (5) @(negedge CPUClk);
    start_req(1'b0, 4'd6, 1'b1, 1'b1);
    st = cyc;
    wait_ack(1'b0, 40000, ea, ca, ta);
`ifdef USART_BAUD_CTRL_LOCK_EN
    check("tmo_ackerr", 32'(ea), 32'd1);
    check("tmo_cfgvalid", 32'(ca), 32'd0);
    check("tmo_min_wait", 32'((ta - st) >= TMO), 32'd1);
    check("tmo_max_wait", 32'((ta - st) <= TMO + 20), 32'd1);
`else
    check("nolock_ackerr", 32'(ea), 32'd0);
    check("nolock_cfgvalid", 32'(ca), 32'd1);
`endif
    check("tmo_cfg_applied", 32'({Baudrate, Mode, Sync}), 32'({4'd6, 1'b1, 1'b1}));

    // reset in the middle of HOLD
    inclk_run = 1'b1;
    repeat (5) @(negedge CPUClk);
    start_req(1'b1, 4'd8, 1'b0, 1'b0);
    repeat (2) @(negedge CPUClk);
    check("mid_hold_entered", 32'({GenReset, Baudrate}), 32'({1'b1, 4'd8}));
    #1;
    Reset = 1'b0;
    ifc.ReqB_Valid = 1'b0;
    #1;
    check("mid_rst_outputs", 32'({GenReset, Baudrate, Mode, Sync, CfgValid}),
          32'({1'b1, 4'd2, 1'b0, 1'b0, 1'b0}));
    @(negedge CPUClk);
    Reset = 1'b1;
    count_genreset(n);
    check("mid_por_hold_cycles", 32'(n), 32'(HOLD));
    wait_cfgvalid("mid_por_cfgvalid", 50);
    repeat (3) @(negedge CPUClk);
    check("mid_no_ack", 32'({n_ack_a[15:0], n_ack_b[15:0]}), 32'({16'd6, 16'd3}));
    check("mid_por_baud", 32'(Baudrate), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
